// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO.
//   DefDataWidth / DefDepth : default geometry of fifo_generator
//   clog2()                 : pointer index width for a given depth
package fifo_pkg;

  localparam int unsigned DefDataWidth = 4;
  localparam int unsigned DefDepth     = 16;

  // Smallest w such that 2**w >= n; returns at least 1.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/fifo_ram_sdp.sv
// Simple dual-port RAM, Depth x DataWidth.
//   clk_i   : clock
//   rst_i   : synchronous active-high reset (clears the read register only)
//   we_i    : write enable; wdata_i stored at waddr_i
//   re_i    : read enable; rdata_o <= mem[raddr_i] on the next edge
//   rdata_o : registered read data, holds when re_i is low
module fifo_ram_sdp #(
  parameter int unsigned DataWidth = 4,
  parameter int unsigned Depth     = 16,
  parameter int unsigned AddrWidth = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] waddr_i,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic                 re_i,
  input  logic [AddrWidth-1:0] raddr_i,
  output logic [DataWidth-1:0] rdata_o
);

  logic [DataWidth-1:0] mem_q [Depth];
  logic [DataWidth-1:0] rdata_q;

  // Storage is not reset; only valid words are ever read back.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fifo_generator.sv
// Single-clock standard-mode (non-FWFT) synchronous FIFO.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset
//   din   : write data, taken when wr_en and not full
//   wr_en : write request
//   rd_en : read request, data appears on dout one cycle later
//   dout  : registered read data, holds when no read is accepted
//   full  : DEPTH words stored (registered)
//   empty : zero words stored (registered)
module fifo_generator
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned DEPTH      = DefDepth
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty
);

  localparam int unsigned ADDR_WIDTH = clog2(DEPTH);
  localparam logic [ADDR_WIDTH:0] DepthCnt = (ADDR_WIDTH + 1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  wr_acc, rd_acc;

  // Acceptance uses the registered flags, i.e. the state before the edge.
  assign wr_acc = wr_en & ~full_q;
  assign rd_acc = rd_en & ~empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    full_d  = (count_d == DepthCnt);
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Reset must also block the RAM ports so no write lands during reset.
  fifo_ram_sdp #(
    .DataWidth (DATA_WIDTH),
    .Depth     (DEPTH),
    .AddrWidth (ADDR_WIDTH)
  ) u_ram (
    .clk_i   (clk),
    .rst_i   (rst),
    .we_i    (wr_acc & ~rst),
    .waddr_i (wr_ptr_q),
    .wdata_i (din),
    .re_i    (rd_acc & ~rst),
    .raddr_i (rd_ptr_q),
    .rdata_o (dout)
  );

  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: tb/tb_fifo_generator.sv
// Scoreboard bench for fifo_generator: the driver keeps a reference queue and
// pushes expected read data; the monitor compares dout/full/empty every cycle.
module tb_fifo_generator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] din = '0;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic [3:0] dout;
  logic       full;
  logic       empty;

  fifo_generator #(
    .DATA_WIDTH (4),
    .DEPTH      (16)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .din   (din),
    .wr_en (wr_en),
    .rd_en (rd_en),
    .dout  (dout),
    .full  (full),
    .empty (empty)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad   = 0;
  logic [3:0] model_q [$];
  logic [3:0] exp_q   [$];
  int         mcount  = 0;
  bit         rd_tag  = 1'b0;
  bit         mon_en  = 1'b0;

  // What the DUT should show after each edge.
  bit         arm      = 1'b0;
  bit         rst_seen = 1'b0;
  int         cnt_vis  = 0;
  logic [3:0] last_q   = '0;

  always @(posedge clk) begin
    arm      <= rd_tag;
    rst_seen <= rst;
    cnt_vis  <= mcount;
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (rst_seen) begin
        last_q = '0;
      end else if (arm) begin
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL scoreboard_underrun: no expected word for read at %0t", $time);
        end else begin
          last_q = exp_q.pop_front();
        end
      end
      total++;
      if (dout !== last_q) begin
        bad++;
        $display("FAIL dout at %0t: got %h want %h", $time, dout, last_q);
      end
      total++;
      if (full !== (cnt_vis == 16)) begin
        bad++;
        $display("FAIL full at %0t: got %b want %b (count %0d)", $time, full, cnt_vis == 16,
                 cnt_vis);
      end
      total++;
      if (empty !== (cnt_vis == 0)) begin
        bad++;
        $display("FAIL empty at %0t: got %b want %b (count %0d)", $time, empty, cnt_vis == 0,
                 cnt_vis);
      end
    end
  end

  // One clock cycle of stimulus; the model decides acceptance from pre-edge state.
  task automatic op(input bit r_st, input bit w, input bit r, input logic [3:0] d);
    bit wacc, racc;
    @(posedge clk);
    #1;
    rst    = r_st;
    wr_en  = w;
    rd_en  = r;
    din    = d;
    rd_tag = 1'b0;
    if (r_st) begin
      model_q.delete();
    end else begin
      wacc = w && (mcount < 16);
      racc = r && (mcount > 0);
      if (racc) begin
        exp_q.push_back(model_q.pop_front());
        rd_tag = 1'b1;
      end
      if (wacc) model_q.push_back(d);
    end
    mcount = model_q.size();
  endtask

  task automatic wr(input logic [3:0] d);
    op(1'b0, 1'b1, 1'b0, d);
  endtask

  task automatic rd();
    op(1'b0, 1'b0, 1'b1, 4'h0);
  endtask

  initial begin
    // 1. reset and idle
    op(1'b1, 1'b0, 1'b0, 4'h0);
    mon_en = 1'b1;
    for (int i = 0; i < 4; i++) op(1'b1, 1'b0, 1'b0, 4'h0);
    op(1'b0, 1'b0, 1'b0, 4'h0);
    for (int i = 0; i < 3; i++) rd();
    // 2. fill with 1..15,0 then overflow with 7
    for (int i = 1; i <= 16; i++) wr(4'(i));
    wr(4'h7);
    op(1'b0, 1'b1, 1'b1, 4'h7);  // overflow with concurrent read: read taken, write dropped
    wr(4'h1);                    // refill slot so the drain below sees 2..15,0,1
    // 3. drain plus one extra read
    for (int i = 0; i < 17; i++) rd();
    // 4a. preload A,B,C then simultaneous read+write of D
    wr(4'hA);
    wr(4'hB);
    wr(4'hC);
    op(1'b0, 1'b1, 1'b1, 4'hD);
    for (int i = 0; i < 3; i++) rd();
    // 4b. simultaneous on empty: write taken, read ignored
    op(1'b0, 1'b1, 1'b1, 4'h5);
    op(1'b0, 1'b0, 1'b0, 4'h0);
    rd();
    // 5. wrap-around
    for (int i = 0; i < 10; i++) wr(4'(i + 3));
    for (int i = 0; i < 10; i++) rd();
    for (int i = 0; i < 12; i++) wr(4'(15 - i));
    for (int i = 0; i < 12; i++) rd();
    // 6. reset mid-operation with concurrent write
    for (int i = 0; i < 8; i++) wr(4'(i + 8));
    op(1'b1, 1'b1, 1'b0, 4'hE);
    op(1'b0, 1'b0, 1'b0, 4'h0);
    wr(4'h9);
    rd();
    op(1'b0, 1'b0, 1'b0, 4'h0);
    op(1'b0, 1'b0, 1'b0, 4'h0);
    @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
